// File: rtl/block_scheduler.sv
// Falling-block scheduler: keeps up to five blocks in age order in slots 0..4.
// On each frame tick the blocks descend, the oldest retires at the bottom, and a new block spawns periodically.
module block_scheduler #(
  parameter int SPAWN_PERIOD = 60,
  parameter int FALL_STEP    = 2,
  parameter int BLOCK_SIZE   = 10,
  parameter int Y_MAX        = 479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       spawn_en,
  input  logic       clear,
  output logic [9:0] BlockX     [0:4],
  output logic [9:0] BlockY     [0:4],
  output logic [9:0] Block_size [0:4],
  output logic [2:0] block_ready,
  output logic       spawn_skip
);

  localparam int             CW         = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(SPAWN_PERIOD - 1);
  localparam logic [10:0]    RETIRE_ADD = 11'(FALL_STEP + BLOCK_SIZE);
  localparam logic [10:0]    Y_LIMIT    = 11'(Y_MAX);
  localparam logic [9:0]     STEP       = 10'(FALL_STEP);
  localparam logic [9:0]     SIZE       = 10'(BLOCK_SIZE);

  logic          frame_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    lfsr_q, lfsr_d;
  logic [2:0]    count_q, count_d;
  logic          skip_q, skip_d;
  logic [9:0]    x_q [0:4], x_d [0:4];
  logic [9:0]    y_q [0:4], y_d [0:4];
  logic [9:0]    s_q [0:4], s_d [0:4];

  logic       tick, retire, attempt, spawn;
  logic [2:0] post_cnt;
  logic [9:0] new_x;
  logic [9:0] sh_x [0:4];
  logic [9:0] sh_y [0:4];

  // NOTE: combinational next-state logic uses blocking '=' with a default for every
  // signal up front, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    tick     = frame_clk & ~frame_prev_q;
    retire   = (count_q != 3'd0) && (({1'b0, y_q[0]} + RETIRE_ADD) > Y_LIMIT);
    post_cnt = count_q - {2'b00, retire};
    attempt  = tick && (cnt_q == CNT_LAST);
    spawn    = attempt && spawn_en && (post_cnt < 3'd5);
    skip_d   = attempt && spawn_en && (post_cnt == 3'd5);
    new_x    = {1'b0, lfsr_q[8:0]} + 10'd64;
    lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    cnt_d    = cnt_q;
    if (tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    count_d  = tick ? post_cnt + {2'b00, spawn} : count_q;

    // A retiring slot 0 is dropped by reading every survivor from one index higher.
    for (int i = 0; i < 4; i++) begin
      sh_x[i] = retire ? x_q[i+1] : x_q[i];
      sh_y[i] = retire ? y_q[i+1] : y_q[i];
    end
    sh_x[4] = x_q[4];
    sh_y[4] = y_q[4];

    for (int i = 0; i < 5; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      s_d[i] = s_q[i];
      if (tick) begin
        if (3'(i) < post_cnt) begin
          x_d[i] = sh_x[i];
          y_d[i] = sh_y[i] + STEP;
          s_d[i] = SIZE;
        end else if (spawn && (3'(i) == post_cnt)) begin
          x_d[i] = new_x;
          y_d[i] = SIZE;
          s_d[i] = SIZE;
        end else begin
          x_d[i] = '0;
          y_d[i] = '0;
          s_d[i] = '0;
        end
      end
    end
  end

  // NOTE: slot registers are reset explicitly because inactive slots must read as 0
  // straight out of reset; sequential state is updated only with non-blocking '<='.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_prev_q <= 1'b0;
      cnt_q        <= '0;
      lfsr_q       <= 10'h001;
      count_q      <= 3'd0;
      skip_q       <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else begin
      frame_prev_q <= frame_clk;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      if (clear) begin
        count_q <= 3'd0;
        skip_q  <= 1'b0;
        for (int i = 0; i < 5; i++) begin
          x_q[i] <= '0;
          y_q[i] <= '0;
          s_q[i] <= '0;
        end
      end else begin
        count_q <= count_d;
        skip_q  <= skip_d;
        for (int i = 0; i < 5; i++) begin
          x_q[i] <= x_d[i];
          y_q[i] <= y_d[i];
          s_q[i] <= s_d[i];
        end
      end
    end
  end

  assign BlockX      = x_q;
  assign BlockY      = y_q;
  assign Block_size  = s_q;
  assign block_ready = count_q;
  assign spawn_skip  = skip_q;

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: three instances (default period, period 4, period 230)
// share one stimulus stream; each scenario task checks the instance it targets.
module tb_block_scheduler;

  logic Clk, Reset, frame_clk, spawn_en, clear;

  logic [9:0] a_x [0:4], a_y [0:4], a_s [0:4];
  logic [2:0] a_rdy;
  logic       a_skip;
  logic [9:0] b_x [0:4], b_y [0:4], b_s [0:4];
  logic [2:0] b_rdy;
  logic       b_skip;
  logic [9:0] c_x [0:4], c_y [0:4], c_s [0:4];
  logic [2:0] c_rdy;
  logic       c_skip;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks_n  = 0;
  int a_skip_n = 0;
  int b_skip_n = 0;

  block_scheduler dut_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spawn_en(spawn_en), .clear(clear),
    .BlockX(a_x), .BlockY(a_y), .Block_size(a_s), .block_ready(a_rdy), .spawn_skip(a_skip)
  );

  block_scheduler #(.SPAWN_PERIOD(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spawn_en(spawn_en), .clear(clear),
    .BlockX(b_x), .BlockY(b_y), .Block_size(b_s), .block_ready(b_rdy), .spawn_skip(b_skip)
  );

  block_scheduler #(.SPAWN_PERIOD(230)) dut_c (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spawn_en(spawn_en), .clear(clear),
    .BlockX(c_x), .BlockY(c_y), .Block_size(c_s), .block_ready(c_rdy), .spawn_skip(c_skip)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(negedge Clk) begin
    if (a_skip) a_skip_n++;
    if (b_skip) b_skip_n++;
  end

  task automatic do_reset();
    @(posedge Clk); #1;
    Reset = 1'b1; frame_clk = 1'b0; clear = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    ticks_n = 0;
  endtask

  // One frame tick: frame_clk high for one cycle, low for one; outputs settle after the first edge.
  task automatic tick(input logic with_clear);
    @(posedge Clk); #1;
    frame_clk = 1'b1; clear = with_clear;
    @(posedge Clk); #1;
    frame_clk = 1'b0; clear = 1'b0;
    ticks_n++;
  endtask

  task automatic run_to(input int n);
    while (ticks_n < n) tick(1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if (a_rdy !== 3'd0) begin n_fail++; $display("FAIL reset_ready: got %0d want 0", a_rdy); end
    n_checks++;
    if (a_skip !== 1'b0) begin n_fail++; $display("FAIL reset_skip: got %0b want 0", a_skip); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (a_x[i] !== 10'd0 || a_y[i] !== 10'd0 || a_s[i] !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_slot%0d: got x=%0d y=%0d s=%0d want 0/0/0", i, a_x[i], a_y[i], a_s[i]);
      end
    end
    Reset = 1'b0;
    ticks_n = 0;
  endtask

  task automatic test_hold_high();
    do_reset();
    spawn_en = 1'b1;
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    frame_clk = 1'b0;
    ticks_n = 1;
    run_to(3);
    n_checks++;
    if (b_rdy !== 3'd0) begin n_fail++; $display("FAIL hold_high_tick3_ready: got %0d want 0", b_rdy); end
    tick(1'b0);
    n_checks++;
    if (b_rdy !== 3'd1) begin n_fail++; $display("FAIL hold_high_tick4_ready: got %0d want 1", b_rdy); end
  endtask

  task automatic test_full();
    int skips_before;
    do_reset();
    spawn_en = 1'b1;
    run_to(20);
    n_checks++;
    if (b_rdy !== 3'd5) begin n_fail++; $display("FAIL full_ready20: got %0d want 5", b_rdy); end
    n_checks++;
    if (b_y[0] !== 10'd42 || b_y[4] !== 10'd10) begin
      n_fail++; $display("FAIL full_y20: got y0=%0d y4=%0d want 42/10", b_y[0], b_y[4]);
    end
    run_to(23);
    skips_before = b_skip_n;
    n_checks++;
    if (b_skip !== 1'b0) begin n_fail++; $display("FAIL full_skip23: got %0b want 0", b_skip); end
    tick(1'b0);
    n_checks++;
    if (b_skip !== 1'b1) begin n_fail++; $display("FAIL full_skip24: got %0b want 1", b_skip); end
    n_checks++;
    if (b_rdy !== 3'd5) begin n_fail++; $display("FAIL full_ready24: got %0d want 5", b_rdy); end
    @(posedge Clk); #1;
    n_checks++;
    if (b_skip !== 1'b0) begin n_fail++; $display("FAIL full_skip_width: got %0b want 0", b_skip); end
    n_checks++;
    if (b_skip_n - skips_before !== 1) begin
      n_fail++; $display("FAIL full_skip_count: got %0d want 1", b_skip_n - skips_before);
    end
  endtask

  task automatic test_spawn_retire();
    do_reset();
    spawn_en = 1'b1;
    run_to(59);
    n_checks++;
    if (a_rdy !== 3'd0) begin n_fail++; $display("FAIL spawn_ready59: got %0d want 0", a_rdy); end
    tick(1'b0);
    n_checks++;
    if (a_rdy !== 3'd1) begin n_fail++; $display("FAIL spawn_ready60: got %0d want 1", a_rdy); end
    n_checks++;
    if (a_y[0] !== 10'd10 || a_s[0] !== 10'd10) begin
      n_fail++; $display("FAIL spawn_slot0: got y=%0d s=%0d want 10/10", a_y[0], a_s[0]);
    end
    n_checks++;
    if (a_x[0] < 10'd64 || a_x[0] > 10'd575) begin
      n_fail++; $display("FAIL spawn_x_range: got %0d want 64..575", a_x[0]);
    end
    n_checks++;
    if (a_x[1] !== 10'd0 || a_y[1] !== 10'd0 || a_s[1] !== 10'd0) begin
      n_fail++; $display("FAIL spawn_slot1_idle: got x=%0d y=%0d s=%0d want 0/0/0", a_x[1], a_y[1], a_s[1]);
    end
    tick(1'b0);
    n_checks++;
    if (a_y[0] !== 10'd12) begin n_fail++; $display("FAIL fall_y61: got %0d want 12", a_y[0]); end
    run_to(289);
    n_checks++;
    if (a_rdy !== 3'd4 || a_y[0] !== 10'd468) begin
      n_fail++; $display("FAIL retire_289: got rdy=%0d y0=%0d want 4/468", a_rdy, a_y[0]);
    end
    tick(1'b0);
    n_checks++;
    if (a_rdy !== 3'd3 || a_y[0] !== 10'd350) begin
      n_fail++; $display("FAIL retire_290: got rdy=%0d y0=%0d want 3/350", a_rdy, a_y[0]);
    end
    n_checks++;
    if (a_x[3] !== 10'd0 || a_y[3] !== 10'd0 || a_s[3] !== 10'd0) begin
      n_fail++; $display("FAIL retire_slot3_idle: got x=%0d y=%0d s=%0d want 0/0/0", a_x[3], a_y[3], a_s[3]);
    end
    run_to(459);
    n_checks++;
    if (c_rdy !== 3'd1 || c_y[0] !== 10'd468) begin
      n_fail++; $display("FAIL simul_459: got rdy=%0d y0=%0d want 1/468", c_rdy, c_y[0]);
    end
    tick(1'b0);
    n_checks++;
    if (c_rdy !== 3'd1 || c_y[0] !== 10'd10) begin
      n_fail++; $display("FAIL simul_460: got rdy=%0d y0=%0d want 1/10", c_rdy, c_y[0]);
    end
    n_checks++;
    if (c_x[1] !== 10'd0 || c_y[1] !== 10'd0 || c_s[1] !== 10'd0) begin
      n_fail++; $display("FAIL simul_slot1_idle: got x=%0d y=%0d s=%0d want 0/0/0", c_x[1], c_y[1], c_s[1]);
    end
  endtask

  task automatic test_clear();
    do_reset();
    spawn_en = 1'b1;
    run_to(180);
    n_checks++;
    if (a_rdy !== 3'd3) begin n_fail++; $display("FAIL clear_pre_ready: got %0d want 3", a_rdy); end
    tick(1'b1);
    n_checks++;
    if (a_rdy !== 3'd0) begin n_fail++; $display("FAIL clear_ready: got %0d want 0", a_rdy); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (a_x[i] !== 10'd0 || a_y[i] !== 10'd0 || a_s[i] !== 10'd0) begin
        n_fail++;
        $display("FAIL clear_slot%0d: got x=%0d y=%0d s=%0d want 0/0/0", i, a_x[i], a_y[i], a_s[i]);
      end
    end
    run_to(239);
    n_checks++;
    if (a_rdy !== 3'd0) begin n_fail++; $display("FAIL clear_ready239: got %0d want 0", a_rdy); end
    tick(1'b0);
    n_checks++;
    if (a_rdy !== 3'd1) begin n_fail++; $display("FAIL clear_counter_kept: got %0d want 1", a_rdy); end
  endtask

  task automatic test_reset_tick();
    run_to(250);
    @(posedge Clk); #1;
    Reset = 1'b1; frame_clk = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; frame_clk = 1'b0;
    ticks_n = 0;
    n_checks++;
    if (a_rdy !== 3'd0 || a_skip !== 1'b0) begin
      n_fail++; $display("FAIL rst_tick_state: got rdy=%0d skip=%0b want 0/0", a_rdy, a_skip);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (a_x[i] !== 10'd0 || a_y[i] !== 10'd0 || a_s[i] !== 10'd0) begin
        n_fail++;
        $display("FAIL rst_tick_slot%0d: got x=%0d y=%0d s=%0d want 0/0/0", i, a_x[i], a_y[i], a_s[i]);
      end
    end
    run_to(59);
    n_checks++;
    if (a_rdy !== 3'd0) begin n_fail++; $display("FAIL rst_tick_ready59: got %0d want 0", a_rdy); end
    tick(1'b0);
    n_checks++;
    if (a_rdy !== 3'd1) begin n_fail++; $display("FAIL rst_tick_ready60: got %0d want 1", a_rdy); end
  endtask

  task automatic test_spawn_disabled();
    int a_before, b_before;
    do_reset();
    spawn_en = 1'b0;
    a_before = a_skip_n;
    b_before = b_skip_n;
    run_to(120);
    n_checks++;
    if (a_rdy !== 3'd0 || b_rdy !== 3'd0 || c_rdy !== 3'd0) begin
      n_fail++; $display("FAIL disabled_ready: got %0d/%0d/%0d want 0/0/0", a_rdy, b_rdy, c_rdy);
    end
    n_checks++;
    if (a_skip_n !== a_before || b_skip_n !== b_before) begin
      n_fail++; $display("FAIL disabled_skip: got %0d/%0d pulses want 0/0", a_skip_n - a_before, b_skip_n - b_before);
    end
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; spawn_en = 1'b0; clear = 1'b0;
    test_reset();
    test_hold_high();
    test_full();
    test_spawn_retire();
    test_clear();
    test_reset_tick();
    test_spawn_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
